// File: rtl/mux_pkg.sv
// Shared definitions for the N:1 selector family: skid-stage state encoding
// and the select-width helper used to size the select port.
package mux_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  // A two-input mux still needs one select bit, so clamp the minimum at 1.
  function automatic int selWidth(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mux_nto1.sv
// Combinational WIDTH x NUM_IN selector. An out-of-range select yields zero
// data with the error flag raised.
module mux_nto1
  import mux_pkg::*;
#(
  parameter int WIDTH  = 5,
  parameter int NUM_IN = 3,
  parameter int SEL_W  = selWidth(NUM_IN)
) (
  input  logic [NUM_IN*WIDTH-1:0] in_bus,
  input  logic [SEL_W-1:0]        sel,
  output logic [WIDTH-1:0]        sel_data,
  output logic                    sel_err
);

  always_comb begin
    sel_data = '0;
    sel_err  = 1'b1;
    for (int k = 0; k < NUM_IN; k++) begin
      if (sel == SEL_W'(k)) begin
        sel_data = in_bus[k*WIDTH +: WIDTH];
        sel_err  = 1'b0;
      end
    end
  end

endmodule

// File: rtl/mux_nto1_skid.sv
// N:1 selector with a two-entry valid/ready skid stage, or a pure
// combinational pass-through when BYPASS is set.
module mux_nto1_skid
  import mux_pkg::*;
#(
  parameter int WIDTH  = 5,
  parameter int NUM_IN = 3,
  parameter int SEL_W  = selWidth(NUM_IN),
  parameter bit BYPASS = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_IN*WIDTH-1:0] in_bus,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_err,
  output logic                    out_valid,
  input  logic                    out_ready
);

  logic [WIDTH-1:0] w_selData;
  logic             w_selErr;

  mux_nto1 #(
    .WIDTH  (WIDTH),
    .NUM_IN (NUM_IN),
    .SEL_W  (SEL_W)
  ) u_mux (
    .in_bus   (in_bus),
    .sel      (sel),
    .sel_data (w_selData),
    .sel_err  (w_selErr)
  );

  if (BYPASS) begin : g_bypass

    assign out_data  = w_selData;
    assign out_err   = w_selErr;
    assign out_valid = in_valid;
    assign in_ready  = out_ready;

  end else begin : g_skid

    state_t           r_state;
    state_t           w_nextState;
    logic [WIDTH-1:0] r_mainData;
    logic             r_mainErr;
    logic [WIDTH-1:0] r_skidData;
    logic             r_skidErr;
    logic             w_acc;
    logic             w_pop;
    logic             w_loadMain;
    logic             w_loadSkid;
    logic             w_mainFromSkid;

    // in_ready comes from the state flops alone, so out_ready never reaches it.
    assign in_ready  = (r_state != ST_TWO);
    assign out_valid = (r_state != ST_EMPTY);
    assign out_data  = r_mainData;
    assign out_err   = r_mainErr;
    assign w_acc     = in_valid && in_ready;
    assign w_pop     = out_valid && out_ready;

    always_comb begin
      w_nextState    = r_state;
      w_loadMain     = 1'b0;
      w_loadSkid     = 1'b0;
      w_mainFromSkid = 1'b0;
      case (r_state)
        ST_EMPTY: begin
          if (w_acc) begin
            w_nextState = ST_ONE;
            w_loadMain  = 1'b1;
          end
        end
        ST_ONE: begin
          if (w_acc && w_pop) begin
            w_loadMain = 1'b1;
          end else if (w_acc) begin
            w_nextState = ST_TWO;
            w_loadSkid  = 1'b1;
          end else if (w_pop) begin
            w_nextState = ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (w_pop) begin
            w_nextState    = ST_ONE;
            w_mainFromSkid = 1'b1;
          end
        end
        default: w_nextState = ST_EMPTY;
      endcase
    end

    // Data registers load only on an accepted beat, so idle X never gets in.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        r_state    <= ST_EMPTY;
        r_mainData <= '0;
        r_mainErr  <= 1'b0;
        r_skidData <= '0;
        r_skidErr  <= 1'b0;
      end else begin
        r_state <= w_nextState;
        if (w_loadMain) begin
          r_mainData <= w_selData;
          r_mainErr  <= w_selErr;
        end else if (w_mainFromSkid) begin
          r_mainData <= r_skidData;
          r_mainErr  <= r_skidErr;
        end
        if (w_loadSkid) begin
          r_skidData <= w_selData;
          r_skidErr  <= w_selErr;
        end
      end
    end

  end

endmodule
